// File: rtl/vga_sync_mux.sv
// vga_sync_mux: parametrised VGA timing generator and layer colour multiplexer.
//   An internal prescaler produces a one-clk pixel strobe (p_tick). The h/v
//   counters advance on each strobe and expose pixel_x/pixel_y to the layer
//   generators. The colour mux, hsync and vsync are registered together on the
//   strobe, so rgb and the syncs lag pixel_x/pixel_y by one pixel period.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bg_rgb          background colour where no layer is on
//   layer_on        per-layer pixel-active flags, layer 0 has highest priority
//   layer_rgb       per-layer colour, layer i at [i*RGB_W +: RGB_W]
//   blank_force     forces black output
//   p_tick          one-clk pixel strobe
//   pixel_x/y       current h/v counts
//   video_on        counters inside the visible area (combinational)
//   frame_start     one-clk pulse on the last pixel of the frame
//   hsync/vsync     registered syncs, active level SYNC_POL
//   rgb             registered pixel colour
module vga_sync_mux #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   RGB_W     = 3,
  parameter int   N_LAYERS  = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic                      blank_force,
  output logic                      p_tick,
  output logic [9:0]                pixel_x,
  output logic [9:0]                pixel_y,
  output logic                      video_on,
  output logic                      frame_start,
  output logic                      hsync,
  output logic                      vsync,
  output logic [RGB_W-1:0]          rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_raw;
  logic             vs_raw;
  logic [RGB_W-1:0] mux_rgb;

  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = p_tick && h_last && v_last;
  assign hs_raw      = (h_cnt >= HS_START) && (h_cnt <= HS_END);
  assign vs_raw      = (v_cnt >= VS_START) && (v_cnt <= VS_END);
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;

  // Scan from the highest index down so the lowest active layer wins.
  always_comb begin
    mux_rgb = bg_rgb;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i]) mux_rgb = layer_rgb[i*RGB_W +: RGB_W];
    end
    if (!video_on || blank_force) mux_rgb = '0;
  end

  // p_tick is registered from the next divider value so it is high exactly
  // while div_cnt == CLK_DIV-1; with CLK_DIV == 1 it stays high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      rgb     <= '0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else begin
      div_cnt <= div_nxt;
      p_tick  <= (div_nxt == DIV_LAST);
      if (p_tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        rgb   <= mux_rgb;
        hsync <= hs_raw ? SYNC_POL : ~SYNC_POL;
        vsync <= vs_raw ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_mux.sv
// tb_vga_sync_mux: directed checks of vga_sync_mux with default timing and a
// small fast-running timing set (CLK_DIV=1, active-high syncs).
module tb_vga_sync_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  bg_rgb;
  logic [8:0]  layer_on;
  logic [26:0] layer_rgb;
  logic        blank_force;

  logic       d_p_tick, d_video_on, d_frame_start, d_hsync, d_vsync;
  logic [9:0] d_pixel_x, d_pixel_y;
  logic [2:0] d_rgb;

  logic       s_p_tick, s_video_on, s_frame_start, s_hsync, s_vsync;
  logic [9:0] s_pixel_x, s_pixel_y;
  logic [2:0] s_rgb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_sync_mux dut_d (
    .clk(clk), .reset(reset), .bg_rgb(bg_rgb), .layer_on(layer_on),
    .layer_rgb(layer_rgb), .blank_force(blank_force), .p_tick(d_p_tick),
    .pixel_x(d_pixel_x), .pixel_y(d_pixel_y), .video_on(d_video_on),
    .frame_start(d_frame_start), .hsync(d_hsync), .vsync(d_vsync), .rgb(d_rgb)
  );

  vga_sync_mux #(
    .CLK_DIV(1), .SYNC_POL(1'b1),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(reset), .bg_rgb(bg_rgb), .layer_on(layer_on),
    .layer_rgb(layer_rgb), .blank_force(blank_force), .p_tick(s_p_tick),
    .pixel_x(s_pixel_x), .pixel_y(s_pixel_y), .video_on(s_video_on),
    .frame_start(s_frame_start), .hsync(s_hsync), .vsync(s_vsync), .rgb(s_rgb)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to the first clk of default-instance pixel (x, y); y < 0 matches any line.
  task automatic wait_d(input int x, input int y, input int bound);
    int  n;
    bit  hit;
    n = 0;
    hit = (d_pixel_x == x) && (y < 0 || d_pixel_y == y);
    while (hit && n < bound) begin
      @(negedge clk); n++;
      hit = (d_pixel_x == x) && (y < 0 || d_pixel_y == y);
    end
    while (!hit && n < bound) begin
      @(negedge clk); n++;
      hit = (d_pixel_x == x) && (y < 0 || d_pixel_y == y);
    end
    check("wait_d reached pixel", int'(hit), 1);
  endtask

  task automatic wait_s_x(input int x, input int bound);
    int n;
    n = 0;
    while (s_pixel_x == x && n < bound) begin @(negedge clk); n++; end
    while (s_pixel_x != x && n < bound) begin @(negedge clk); n++; end
    check("wait_s_x reached pixel", int'(s_pixel_x == x), 1);
  endtask

  initial begin
    int t1, t2, y1, n, cnt, first, last;

    reset       = 1'b1;
    bg_rgb      = 3'b111;
    layer_on    = '0;
    // {L8..L0}
    layer_rgb   = {3'd7, 3'd7, 3'd7, 3'd7, 3'b010, 3'b110, 3'b100, 3'b011, 3'b001};
    blank_force = 1'b0;

    repeat (3) @(negedge clk);
    check("reset pixel_x", d_pixel_x, 0);
    check("reset pixel_y", d_pixel_y, 0);
    check("reset rgb", d_rgb, 0);
    check("reset hsync", d_hsync, 1);
    check("reset vsync", d_vsync, 1);
    check("reset p_tick", d_p_tick, 0);
    check("reset frame_start", d_frame_start, 0);
    check("reset video_on", d_video_on, 1);
    check("reset small hsync", s_hsync, 0);
    check("reset small vsync", s_vsync, 0);
    check("reset small p_tick", s_p_tick, 0);
    reset = 1'b0;

    // First strobe three clks after release, then every 4 clks.
    t1 = cyc;
    n = 0;
    while (!d_p_tick && n < 20) begin @(negedge clk); n++; end
    check("first p_tick delay", cyc - t1, 3);
    t1 = cyc;
    @(negedge clk);
    n = 0;
    while (!d_p_tick && n < 20) begin @(negedge clk); n++; end
    check("p_tick period", cyc - t1, 4);
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += int'(d_p_tick); end
    check("p_tick count in 40 clk", cnt, 10);

    // Line length and wrap.
    wait_d(5, -1, 4000);
    t1 = cyc; y1 = d_pixel_y;
    wait_d(5, -1, 4000);
    check("line length clk", cyc - t1, 3200);
    check("line y increment", d_pixel_y, y1 + 1);
    wait_d(799, -1, 4000);
    y1 = d_pixel_y;
    wait_d(0, -1, 100);
    check("wrap y increment", d_pixel_y, y1 + 1);

    // hsync across one line: at each strobe hsync reflects the previous pixel.
    cnt = 0; first = -1; last = -1;
    for (int k = 0; k < 800; k++) begin
      n = 0;
      while (!d_p_tick && n < 8) begin @(negedge clk); n++; end
      if (!d_hsync) begin
        cnt++;
        if (first < 0) first = d_pixel_x;
        last = d_pixel_x;
      end
      @(negedge clk);
    end
    check("hsync low ticks", cnt, 96);
    check("hsync first low x", first, 657);
    check("hsync last low x", last, 752);

    // Priority mux at pixel (10,10).
    wait_d(10, 10, 40000);
    layer_on = 9'b000010100;
    wait_d(11, 10, 100);
    check("priority layer2", d_rgb, 3'b100);
    layer_on = 9'b000000000;
    @(negedge clk);
    check("rgb holds between ticks", d_rgb, 3'b100);
    wait_d(12, 10, 100);
    check("no layer -> bg", d_rgb, 3'b111);
    layer_on = 9'b000010000;
    blank_force = 1'b1;
    @(negedge clk);
    blank_force = 1'b0;
    wait_d(13, 10, 100);
    check("blank glitch ignored, layer4", d_rgb, 3'b010);
    layer_on = 9'b000010101;
    wait_d(14, 10, 100);
    check("priority layer0", d_rgb, 3'b001);
    blank_force = 1'b1;
    wait_d(15, 10, 100);
    check("blank_force visible", d_rgb, 0);
    blank_force = 1'b0;
    layer_on = 9'b000010100;
    wait_d(640, 10, 4000);
    check("rgb at x=640 (pixel 639)", d_rgb, 3'b100);
    check("video_on at x=640", d_video_on, 0);
    wait_d(641, 10, 100);
    check("blanked at x=640", d_rgb, 0);

    // Mid-line reset.
    wait_d(300, 11, 4000);
    reset = 1'b1;
    @(negedge clk);
    check("midreset pixel_x", d_pixel_x, 0);
    check("midreset pixel_y", d_pixel_y, 0);
    check("midreset rgb", d_rgb, 0);
    check("midreset hsync", d_hsync, 1);
    check("midreset vsync", d_vsync, 1);
    check("midreset p_tick", d_p_tick, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("resume pixel_x", d_pixel_x, 1);
    check("resume pixel_y", d_pixel_y, 0);
    check("resume rgb pixel0", d_rgb, 3'b100);

    // Small instance: CLK_DIV=1, active-high syncs, 15x7 frame.
    cnt = 0;
    repeat (30) begin @(negedge clk); cnt += int'(s_p_tick); end
    check("small p_tick constant", cnt, 30);
    wait_s_x(3, 100);
    t1 = cyc;
    wait_s_x(3, 100);
    check("small line clk", cyc - t1, 15);

    n = 0;
    while (!s_frame_start && n < 300) begin @(negedge clk); n++; end
    t1 = cyc;
    check("small frame_start x", s_pixel_x, 14);
    check("small frame_start y", s_pixel_y, 6);
    @(negedge clk);
    n = 0;
    while (!s_frame_start && n < 300) begin @(negedge clk); n++; end
    t2 = cyc;
    check("small frame period", t2 - t1, 105);

    wait_s_x(0, 100);
    cnt = 0; first = -1;
    repeat (15) begin
      if (s_hsync) begin
        cnt++;
        if (first < 0) first = s_pixel_x;
      end
      @(negedge clk);
    end
    check("small hsync high ticks", cnt, 3);
    check("small hsync first x", first, 11);

    cnt = 0; first = -1;
    repeat (105) begin
      @(negedge clk);
      if (s_pixel_x == 1 && s_vsync) begin
        cnt++;
        first = s_pixel_y;
      end
    end
    check("small vsync lines", cnt, 1);
    check("small vsync line y", first, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
